// File: rtl/frame_aligner.sv
// Byte-stream frame aligner: hunts for 12-byte frames led by a 0xAFAA or 0xBA55
// header, locks after three evenly spaced headers, and drops lock after four bad ones.
module frame_aligner (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  output logic [3:0] fr_byte_position,
  output logic       frame_detect
);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t     state;
  logic [3:0] pos;
  logic [1:0] vcnt;
  logic [2:0] icnt;
  logic [7:0] prev;
  logic       hdr_ok;
  logic [3:0] pos_nxt;

  // Header is sent LSB first, so the history byte holds the LSB.
  assign hdr_ok  = ((prev == 8'hAA) && (rx_data == 8'hAF)) ||
                   ((prev == 8'h55) && (rx_data == 8'hBA));
  assign pos_nxt = (pos == 4'd11) ? 4'd0 : pos + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= SEARCH;
      pos              <= 4'd0;
      vcnt             <= 2'd0;
      icnt             <= 3'd0;
      prev             <= 8'd0;
      frame_detect     <= 1'b0;
      fr_byte_position <= 4'd0;
    end else begin
      prev <= rx_data;
      case (state)
        SEARCH: begin
          fr_byte_position <= 4'd0;
          if (hdr_ok) begin
            state <= TRACK;
            pos   <= 4'd1;
            vcnt  <= 2'd1;
          end
        end
        TRACK: begin
          pos <= pos_nxt;
          // Only the pair landing on position 1 counts; headers elsewhere are payload.
          if (pos_nxt == 4'd1) begin
            if (!hdr_ok) begin
              state <= SEARCH;
              pos   <= 4'd0;
              vcnt  <= 2'd0;
            end else if (vcnt == 2'd2) begin
              state            <= LOCKED;
              vcnt             <= 2'd3;
              icnt             <= 3'd0;
              frame_detect     <= 1'b1;
              fr_byte_position <= pos_nxt;
            end else begin
              vcnt <= vcnt + 2'd1;
            end
          end
        end
        LOCKED: begin
          pos              <= pos_nxt;
          fr_byte_position <= pos_nxt;
          if (pos_nxt == 4'd1) begin
            if (hdr_ok) begin
              icnt <= 3'd0;
            end else if (icnt == 3'd3) begin
              state            <= SEARCH;
              pos              <= 4'd0;
              vcnt             <= 2'd0;
              icnt             <= 3'd0;
              frame_detect     <= 1'b0;
              fr_byte_position <= 4'd0;
            end else begin
              icnt <= icnt + 3'd1;
            end
          end
        end
        default: begin
          state            <= SEARCH;
          pos              <= 4'd0;
          vcnt             <= 2'd0;
          icnt             <= 3'd0;
          frame_detect     <= 1'b0;
          fr_byte_position <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_aligner.sv
// Directed checks of frame_aligner: acquisition, loss of lock, mid-frame headers,
// reset behaviour and a stretch of header-free noise.
module tb_frame_aligner;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic [3:0] fr_byte_position;
  logic       frame_detect;

  int n_vec = 0;
  int n_err = 0;

  frame_aligner dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .fr_byte_position (fr_byte_position),
    .frame_detect     (frame_detect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte, let it be sampled, then check the registered outputs.
  task automatic send(input logic [7:0] b, input logic efd, input logic [3:0] epos,
                      input string tag);
    rx_data = b;
    @(posedge clk);
    #1;
    chk({tag, ".fd"},  {7'd0, frame_detect}, {7'd0, efd});
    chk({tag, ".pos"}, {4'd0, fr_byte_position}, {4'd0, epos});
  endtask

  // One 12-byte frame; lk0 = lock expected while the LSB is sampled,
  // lk1 = lock expected from the MSB onward. Payload bytes are 0x02..0x0B.
  task automatic frame(input logic [7:0] l, input logic [7:0] m,
                       input logic lk0, input logic lk1, input string tag);
    send(l, lk0, 4'd0, {tag, ".b0"});
    send(m, lk1, lk1 ? 4'd1 : 4'd0, {tag, ".b1"});
    for (int i = 2; i < 12; i++)
      send(8'(i), lk1, lk1 ? 4'(i) : 4'd0, {tag, ".pl"});
  endtask

  task automatic do_reset(input logic [7:0] b);
    reset   = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
    chk("rst.fd",  {7'd0, frame_detect}, 8'd0);
    chk("rst.pos", {4'd0, fr_byte_position}, 8'd0);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rx_data = 8'h00;
    @(posedge clk);
    do_reset(8'h00);

    // Acquisition with HEAD_1: lock on the third header's MSB.
    frame(8'hAA, 8'hAF, 0, 0, "h1a");
    frame(8'hAA, 8'hAF, 0, 0, "h1b");
    frame(8'hAA, 8'hAF, 0, 1, "h1c");
    frame(8'hAA, 8'hAF, 1, 1, "h1d");

    // Three bad headers then a good one keeps lock; four bad in a row drops it.
    frame(8'h12, 8'h34, 1, 1, "bad1");
    frame(8'h12, 8'h34, 1, 1, "bad2");
    frame(8'h12, 8'h34, 1, 1, "bad3");
    frame(8'hAA, 8'hAF, 1, 1, "good");
    frame(8'h12, 8'h34, 1, 1, "lose1");
    frame(8'h12, 8'h34, 1, 1, "lose2");
    frame(8'h12, 8'h34, 1, 1, "lose3");
    frame(8'h12, 8'h34, 1, 0, "lose4");

    // Mixed header types relock from SEARCH.
    frame(8'h55, 8'hBA, 0, 0, "mixa");
    frame(8'hAA, 8'hAF, 0, 0, "mixb");
    frame(8'h55, 8'hBA, 0, 1, "mixc");

    // Header-shaped payload at positions 5/6 is ignored while locked.
    send(8'hAA, 1, 4'd0, "pay.b0");
    send(8'hAF, 1, 4'd1, "pay.b1");
    for (int i = 2; i < 12; i++)
      send((i == 5) ? 8'hAA : (i == 6) ? 8'hAF : 8'(i), 1, 4'(i), "pay.pl");
    frame(8'hAA, 8'hAF, 1, 1, "pay.next");

    // Reset mid-frame while locked discards alignment; three fresh headers relock.
    send(8'hAA, 1, 4'd0, "mid.b0");
    send(8'hAF, 1, 4'd1, "mid.b1");
    send(8'h02, 1, 4'd2, "mid.b2");
    do_reset(8'h00);
    frame(8'hAA, 8'hAF, 0, 0, "rlk1");
    frame(8'hAA, 8'hAF, 0, 0, "rlk2");
    frame(8'hAA, 8'hAF, 0, 1, "rlk3");

    // Two good headers then 0x1234: back to SEARCH, so one more good header is not enough.
    do_reset(8'h00);
    frame(8'hAA, 8'hAF, 0, 0, "trk1");
    frame(8'hAA, 8'hAF, 0, 0, "trk2");
    frame(8'h34, 8'h12, 0, 0, "trkbad");
    frame(8'hAA, 8'hAF, 0, 0, "trk3");

    // History cleared by reset: 0xAF right after reset (0xAA during reset) is not a header.
    do_reset(8'hAA);
    frame(8'h00, 8'hAF, 0, 0, "hist0");
    frame(8'hAA, 8'hAF, 0, 0, "hist1");
    frame(8'hAA, 8'hAF, 0, 0, "hist2");

    // Header-free noise never locks.
    do_reset(8'h00);
    for (int i = 0; i < 200; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      if (r == 8'hAA || r == 8'h55) r = 8'h00;
      send(r, 0, 4'd0, "noise");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
